control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the DataPath control strobes in place of the bench-driven T0..T5 sequences.
//  Runs fetch (T0-T2) and then the execute steps for each instruction class, decoded from the IR value the DataPath exposes.
//  Sits directly upstream of DataPath; every output connects 1:1 to a DataPath control input.
// PARAMETERS
//  NREG   16  number of GPRs; sets the width of r_in/r_out
//  OPW    5   opcode width (ir[31:27])
// PORTS
//  clock      in   1   single clock; all state changes on posedge
//  clear      in   1   synchronous, active-high reset
//  ir         in   32  DataPath IR contents: op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15], C=ir[18:0]
//  mem_ready  in   1   memory has data valid on Mdatain; sampled only in T1
//  pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out    out 1  bus-drive strobes
//  pc_in, mar_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhigh_in, zlow_in, inc_pc, read  out 1  load/ctrl strobes
//  alu_op     out  5   ALU opcode; equals ir[31:27] in ALU steps, else 5'b00000
//  r_in       out  NREG one-hot GPR load enable
//  r_out      out  NREG one-hot GPR bus drive
//  run        out  1   1 while executing; 0 in HALT
//  illegal    out  1   one-cycle pulse in T3 when the opcode is undefined
// BEHAVIOUR
//  - Moore FSM: outputs decode from the registered state plus ir; no combinational path from mem_ready to any output.
//  - States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. Each state lasts one clock; T1 is the only wait state.
//  - clear=1 at a posedge -> next state RST from any state, including mid-instruction or a T1 wait.
//    In RST: all outputs 0, run=0. RST goes to T0 unconditionally.
//  - T0: pc_out, mar_in, inc_pc, pc_in (PC+1 loaded in place).
//  - T1: read, mdr_in. Stays in T1 while mem_ready=0; goes to T2 on the edge where mem_ready=1.
//  - T2: mdr_out, ir_in. The new IR is valid on ir from T3 onward.
//  - R-type ALU (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
//      T3 r_out[Rb], y_in | T4 r_out[Rc], alu_op, zlow_in | T5 zlow_out, r_in[Ra] -> T0.
//      Result: Ra = Rb op Rc.
//  - Immediate (addi 01100, andi 01101, ori 01110):
//      T3 r_out[Rb], y_in | T4 c_out, alu_op, zlow_in | T5 zlow_out, r_in[Ra] -> T0.
//  - mul 10000 / div 01111:
//      T3 r_out[Ra], y_in | T4 r_out[Rb], alu_op, zhigh_in, zlow_in | T5 zlow_out, lo_in | T6 zhigh_out, hi_in -> T0.
//  - Unary (neg 10001, not 10010): T3 r_out[Rb], alu_op, zlow_in | T4 zlow_out, r_in[Ra] -> T0.
//  - nop 11010: T3 with no strobes asserted -> T0.
//  - halt 11011: T3 -> HALT. HALT holds all strobes at 0 and run=0 until clear.
//  - Any other opcode: illegal=1 for the T3 cycle, no strobes asserted -> T0.
//  - r_in/r_out: at most one bit set per cycle; Ra=Rb=Rc is legal, with no special handling.
//  - No more than one bus driver is asserted in any state (one-hot bus invariant).
// STRUCTURE
//  - cpu_ctrl_pkg holds opcode localparams, state encodings, and IR field bit positions;
//    DataPath and ALU share it for alu_op.
//  - Sub-module reg_select_decoder: 4-bit field -> NREG one-hot, with an enable.
//    Instantiated twice: once for r_in, once for r_out. The field mux is selected by state.
//  - Target size ~200-300 lines; the FSM is a single case on state.
// TESTING
//  1. clear=1 for 2 clocks, then 0 -> RST for one cycle with all outputs 0, then T0 with pc_out=mar_in=inc_pc=pc_in=1.
//  2. mem_ready held 0 for 3 cycles in T1 -> read=mdr_in=1 for 4 cycles; T2 follows the mem_ready=1 edge.
//  3. ir=32'h3A1B8000 (ror R4,R3,R7):
//       T3 r_out=16'h0008, y_in | T4 r_out=16'h0080, alu_op=5'b00111 | T5 r_in=16'h0010.
//     With the DataPath attached, R3=0x7F and R7=0x01 give R4=0x8000003F.
//  4. mul R2,R3 with R2=6, R3=-3 -> T5 lo_in, T6 hi_in; LO=0xFFFFFFEE, HI=0xFFFFFFFF, next state T0.
//  5. ir op=11011 -> run=0 from the cycle after T3 and stays in HALT for 20 clocks.
//     ir op=11111 -> illegal pulses once, then T0.
//  6. clear asserted during T4 of add -> next cycle RST with all strobes 0; Ra unchanged.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer.
//   - state_e     : sequencer state encoding (RST, T0..T6, HALT)
//   - op_class_e  : instruction class derived from the opcode
//   - OP_*        : opcode values, shared with the DataPath/ALU for alu_op
//   - IR field positions and extraction helpers
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_IMM,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    function automatic logic [4:0] ir_op(input logic [31:0] ir);
        return ir[OP_LSB +: 5];
    endfunction

    function automatic logic [3:0] ir_ra(input logic [31:0] ir);
        return ir[RA_LSB +: 4];
    endfunction

    function automatic logic [3:0] ir_rb(input logic [31:0] ir);
        return ir[RB_LSB +: 4];
    endfunction

    function automatic logic [3:0] ir_rc(input logic [31:0] ir);
        return ir[RC_LSB +: 4];
    endfunction

    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       c = C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:              c = C_IMM;
            OP_MUL, OP_DIV:                        c = C_MULDIV;
            OP_NEG, OP_NOT:                        c = C_UNARY;
            OP_NOP:                                c = C_NOP;
            OP_HALT:                               c = C_HALT;
            default:                               c = C_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the DataPath.
//   master : sequencer side (reads ir/mem_ready, drives every strobe)
//   slave  : DataPath side (drives ir/mem_ready, receives strobes)
interface control_sequencer_if #(parameter int NREG = 16);
    logic [31:0]     ir;
    logic            mem_ready;
    logic            pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out;
    logic            pc_in, mar_in, mdr_in, ir_in, y_in, hi_in, lo_in;
    logic            zhigh_in, zlow_in, inc_pc, read;
    logic [4:0]      alu_op;
    logic [NREG-1:0] r_in;
    logic [NREG-1:0] r_out;
    logic            run;
    logic            illegal;

    modport master (
        input  ir, mem_ready,
        output pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out,
               pc_in, mar_in, mdr_in, ir_in, y_in, hi_in, lo_in,
               zhigh_in, zlow_in, inc_pc, read, alu_op, r_in, r_out, run, illegal
    );

    modport slave (
        output ir, mem_ready,
        input  pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out,
               pc_in, mar_in, mdr_in, ir_in, y_in, hi_in, lo_in,
               zhigh_in, zlow_in, inc_pc, read, alu_op, r_in, r_out, run, illegal
    );
endinterface

// File: rtl/control_sequencer_reg_select_decoder.sv
// reg_select_decoder: turns a 4-bit register field into a one-hot GPR enable.
//   field  : register number
//   en     : when 0 the output is all zeros
//   onehot : NREG-wide one-hot select (zero if field addresses no GPR)
module reg_select_decoder #(
    parameter int NREG = 16
) (
    input  logic [3:0]      field,
    input  logic            en,
    output logic [NREG-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en && (int'(field) < NREG)) begin
            onehot = NREG'(1) << field;
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the DataPath.
// Runs fetch (T0-T2), then the execute steps of the decoded instruction class.
//   clock : single clock, all state changes on posedge
//   clear : synchronous active-high reset to RST
//   bus   : master side of control_sequencer_if (ir/mem_ready in, strobes out)
// Outputs decode from the registered state plus ir only; mem_ready only
// steers the next state, so it never reaches an output combinationally.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);
    state_e         state_q, state_d;
    logic [OPW-1:0] op;
    op_class_e      cls;
    logic [3:0]     ra, rb, rc;
    logic [3:0]     rin_sel, rout_sel;
    logic           rin_en, rout_en;

    assign op  = OPW'(ir_op(bus.ir));
    assign cls = op_class(5'(op));
    assign ra  = ir_ra(bus.ir);
    assign rb  = ir_rb(bus.ir);
    assign rc  = ir_rc(bus.ir);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                case (cls)
                    C_HALT:             state_d = S_HALT;
                    C_NOP, C_ILLEGAL:   state_d = S_T0;
                    default:            state_d = S_T4;
                endcase
            end
            S_T4:   state_d = (cls == C_UNARY) ? S_T0 : S_T5;
            S_T5:   state_d = (cls == C_MULDIV) ? S_T6 : S_T0;
            S_T6:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
        if (clear) state_d = S_RST;
    end

    always_ff @(posedge clock) begin
        state_q <= state_d;
    end

    always_comb begin
        bus.pc_out = 1'b0; bus.mdr_out = 1'b0; bus.zhigh_out = 1'b0;
        bus.zlow_out = 1'b0; bus.hi_out = 1'b0; bus.lo_out = 1'b0;
        bus.c_out = 1'b0; bus.pc_in = 1'b0; bus.mar_in = 1'b0;
        bus.mdr_in = 1'b0; bus.ir_in = 1'b0; bus.y_in = 1'b0;
        bus.hi_in = 1'b0; bus.lo_in = 1'b0; bus.zhigh_in = 1'b0;
        bus.zlow_in = 1'b0; bus.inc_pc = 1'b0; bus.read = 1'b0;
        bus.alu_op = 5'b00000;
        bus.illegal = 1'b0;
        bus.run = 1'b0;
        rin_en = 1'b0; rin_sel = ra;
        rout_en = 1'b0; rout_sel = rb;
        case (state_q)
            S_T0: begin
                bus.run = 1'b1;
                bus.pc_out = 1'b1; bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1; bus.pc_in = 1'b1;
            end
            S_T1: begin
                bus.run = 1'b1;
                bus.read = 1'b1; bus.mdr_in = 1'b1;
            end
            S_T2: begin
                bus.run = 1'b1;
                bus.mdr_out = 1'b1; bus.ir_in = 1'b1;
            end
            S_T3: begin
                bus.run = 1'b1;
                case (cls)
                    C_RTYPE, C_IMM: begin
                        rout_en = 1'b1; bus.y_in = 1'b1;
                    end
                    C_MULDIV: begin
                        rout_en = 1'b1; rout_sel = ra; bus.y_in = 1'b1;
                    end
                    C_UNARY: begin
                        rout_en = 1'b1; bus.alu_op = 5'(op); bus.zlow_in = 1'b1;
                    end
                    C_ILLEGAL: bus.illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                bus.run = 1'b1;
                case (cls)
                    C_RTYPE: begin
                        rout_en = 1'b1; rout_sel = rc;
                        bus.alu_op = 5'(op); bus.zlow_in = 1'b1;
                    end
                    C_IMM: begin
                        bus.c_out = 1'b1; bus.alu_op = 5'(op); bus.zlow_in = 1'b1;
                    end
                    C_MULDIV: begin
                        rout_en = 1'b1; bus.alu_op = 5'(op);
                        bus.zhigh_in = 1'b1; bus.zlow_in = 1'b1;
                    end
                    C_UNARY: begin
                        bus.zlow_out = 1'b1; rin_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                bus.run = 1'b1;
                bus.zlow_out = 1'b1;
                // mul/div park the low word in LO; everything else writes Ra.
                if (cls == C_MULDIV) bus.lo_in = 1'b1;
                else rin_en = 1'b1;
            end
            S_T6: begin
                bus.run = 1'b1;
                bus.zhigh_out = 1'b1; bus.hi_in = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select_decoder #(.NREG(NREG)) u_rin_dec (
        .field  (rin_sel),
        .en     (rin_en),
        .onehot (bus.r_in)
    );

    reg_select_decoder #(.NREG(NREG)) u_rout_dec (
        .field  (rout_sel),
        .en     (rout_en),
        .onehot (bus.r_out)
    );
endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    typedef logic [56:0] vec_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    control_sequencer_if #(.NREG(16)) bus ();

    control_sequencer #(.NREG(16), .OPW(5)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    // Output vector layout: strobes [56:39], alu_op [38:34], r_in [33:18],
    // r_out [17:2], run [1], illegal [0].
    function automatic vec_t b(input int i);
        return vec_t'(1) << i;
    endfunction
    function automatic vec_t rin(input int r);
        return vec_t'(1) << (18 + r);
    endfunction
    function automatic vec_t rout(input int r);
        return vec_t'(1) << (2 + r);
    endfunction
    function automatic vec_t aop(input int op);
        return vec_t'(op) << 34;
    endfunction

    localparam int PC_OUT = 56, MDR_OUT = 55, ZHIGH_OUT = 54, ZLOW_OUT = 53;
    localparam int C_OUT = 50, PC_IN = 49, MAR_IN = 48, MDR_IN = 47;
    localparam int IR_IN = 46, Y_IN = 45, HI_IN = 44, LO_IN = 43;
    localparam int ZHIGH_IN = 42, ZLOW_IN = 41, INC_PC = 40, READ = 39;

    function automatic vec_t obs();
        return {bus.pc_out, bus.mdr_out, bus.zhigh_out, bus.zlow_out, bus.hi_out,
                bus.lo_out, bus.c_out, bus.pc_in, bus.mar_in, bus.mdr_in, bus.ir_in,
                bus.y_in, bus.hi_in, bus.lo_in, bus.zhigh_in, bus.zlow_in,
                bus.inc_pc, bus.read, bus.alu_op, bus.r_in, bus.r_out,
                bus.run, bus.illegal};
    endfunction

    function automatic vec_t v_t0();
        return b(1) | b(PC_OUT) | b(MAR_IN) | b(INC_PC) | b(PC_IN);
    endfunction
    function automatic vec_t v_t1();
        return b(1) | b(READ) | b(MDR_IN);
    endfunction
    function automatic vec_t v_t2();
        return b(1) | b(MDR_OUT) | b(IR_IN);
    endfunction

    // Reference: per-instruction-class step table. Returns 1 for halt.
    function automatic bit build_exec(input logic [31:0] ir);
        int op, ra, rb, rc;
        vec_t run1;
        op = int'(ir[31:27]); ra = int'(ir[26:23]);
        rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        run1 = b(1);
        exp_q.delete();
        if (op >= 3 && op <= 11) begin
            exp_q.push_back(run1 | rout(rb) | b(Y_IN));
            exp_q.push_back(run1 | rout(rc) | aop(op) | b(ZLOW_IN));
            exp_q.push_back(run1 | b(ZLOW_OUT) | rin(ra));
        end else if (op >= 12 && op <= 14) begin
            exp_q.push_back(run1 | rout(rb) | b(Y_IN));
            exp_q.push_back(run1 | b(C_OUT) | aop(op) | b(ZLOW_IN));
            exp_q.push_back(run1 | b(ZLOW_OUT) | rin(ra));
        end else if (op == 15 || op == 16) begin
            exp_q.push_back(run1 | rout(ra) | b(Y_IN));
            exp_q.push_back(run1 | rout(rb) | aop(op) | b(ZHIGH_IN) | b(ZLOW_IN));
            exp_q.push_back(run1 | b(ZLOW_OUT) | b(LO_IN));
            exp_q.push_back(run1 | b(ZHIGH_OUT) | b(HI_IN));
        end else if (op == 17 || op == 18) begin
            exp_q.push_back(run1 | rout(rb) | aop(op) | b(ZLOW_IN));
            exp_q.push_back(run1 | b(ZLOW_OUT) | rin(ra));
        end else if (op == 26) begin
            exp_q.push_back(run1);
        end else if (op == 27) begin
            exp_q.push_back(run1);
            return 1'b1;
        end else begin
            exp_q.push_back(run1 | b(0));
        end
        return 1'b0;
    endfunction

    task automatic step(input vec_t e, input string tag);
        vec_t o;
        @(negedge clk);
        o = obs();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic do_clear(input int n);
        clear = 1'b1;
        for (int i = 0; i < n; i++) begin
            step('0, "rst");
            if (i == n - 1) clear = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] new_ir, input int waits);
        step(v_t0(), "t0");
        bus.mem_ready = 1'($urandom);
        for (int i = 0; i <= waits; i++) begin
            step(v_t1(), "t1");
            bus.mem_ready = (i == waits);
        end
        step(v_t2(), "t2");
        bus.ir = new_ir;
        bus.mem_ready = 1'($urandom);
    endtask

    task automatic run_instr(input logic [31:0] ir, input int waits);
        bit halted;
        fetch(ir, waits);
        halted = build_exec(ir);
        foreach (exp_q[i]) begin
            step(exp_q[i], "exec");
            bus.mem_ready = 1'($urandom);
        end
        if (halted) begin
            for (int i = 0; i < 20; i++) step('0, "halt");
            do_clear(1);
        end
    endtask

    initial begin
        logic [31:0] rir;
        bus.ir = 32'h0;
        bus.mem_ready = 1'b0;

        // Reset held two clocks, then fetch with a three-cycle memory wait.
        do_clear(2);
        run_instr(32'h3A1B8000, 3);

        // mul R2,R3 then add, nop, unary and an undefined opcode.
        run_instr({5'b10000, 4'd2, 4'd3, 19'd0}, 0);
        run_instr({5'b00011, 4'd5, 4'd5, 4'd5, 15'd0}, 1);
        run_instr({5'b11010, 27'h5A5A5A5}, 0);
        run_instr({5'b10010, 4'd9, 4'd1, 19'd0}, 2);
        run_instr({5'b11111, 27'h1234567}, 0);
        run_instr({5'b01100, 4'd1, 4'd15, 19'h7FFFF}, 0);

        // Halt: run drops and stays low for 20 clocks until clear.
        run_instr({5'b11011, 27'd0}, 0);

        // Clear in T4 of add.
        fetch({5'b00011, 4'd4, 4'd6, 4'd8, 15'd0}, 0);
        void'(build_exec(bus.ir));
        step(exp_q[0], "add_t3");
        step(exp_q[1], "add_t4");
        clear = 1'b1;
        step('0, "clr_mid");
        clear = 1'b0;

        // Clear during a T1 wait.
        step(v_t0(), "t0");
        bus.mem_ready = 1'b0;
        step(v_t1(), "t1");
        clear = 1'b1;
        step('0, "clr_wait");
        clear = 1'b0;

        // Randomised instruction stream.
        for (int n = 0; n < 150; n++) begin
            rir = $urandom;
            run_instr(rir, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
